// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core (m0) over debug (m1) with a starvation guard.
// Checks alignment, drives the memory port and routes read data back.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic              err_q, err_d;
  logic              ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic              pick1, gnt_any, legal;
  logic              sel_we, sel_uns;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // m1 wins when alone, or when it has waited out the limit
  assign pick1 = m1_req & (~m0_req | (starve_q == LIMIT));
  assign m1_gnt = rst & pick1;
  assign m0_gnt = rst & m0_req & ~pick1;
  assign gnt_any = m0_gnt | m1_gnt;
  assign core_stall = m0_req & ~m0_gnt;

  assign sel_we    = m1_gnt ? m1_we       : m0_we;
  assign sel_uns   = m1_gnt ? m1_unsigned : m0_unsigned;
  assign sel_size  = m1_gnt ? m1_size     : m0_size;
  assign sel_addr  = m1_gnt ? m1_addr     : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata    : m0_wdata;

  always_comb begin
    legal = 1'b1;
    unique case (sel_size)
      2'b00: legal = 1'b1;
      2'b01: legal = ~sel_addr[0];
      2'b10: legal = (sel_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign mem_en       = gnt_any & legal;
  assign mem_we       = mem_en & sel_we;
  assign mem_size     = gnt_any ? sel_size  : size_q;
  assign mem_unsigned = gnt_any ? sel_uns   : uns_q;
  assign mem_addr     = gnt_any ? sel_addr  : addr_q;
  assign mem_wdata    = gnt_any ? sel_wdata : wdata_q;

  always_comb begin
    starve_d = 4'd0;
    if (m0_req & m1_req & m0_gnt)
      starve_d = starve_q + 4'd1;
    rv0_d = m0_gnt;
    rv1_d = m1_gnt;
    err_d = gnt_any & ~legal;
    ld_d  = mem_en & ~sel_we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= 4'd0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      err_q    <= err_d;
      ld_q     <= ld_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      size_q   <= mem_size;
      uns_q    <= mem_unsigned;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_err    = rv0_q & err_q;
  assign m1_err    = rv1_q & err_q;
  assign m0_rdata  = (rv0_q & ld_q) ? mem_rdata : '0;
  assign m1_rdata  = (rv1_q & ld_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural model plus directed literal checks.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_unsigned;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_unsigned;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, mem_unsigned, core_stall;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_at(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic bit bad_access(input logic [1:0] sz,
                                    input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
           (sz == 2'd2 && (a % 4) != 0);
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // simple memory: one-cycle read latency, garbage on non-read cycles
  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? data_at(mem_addr) : 32'hBAD0BAD0;

  typedef struct packed {
    bit v0; bit v1; bit err; bit ld; logic [31:0] data;
  } resp_t;

  resp_t pend = '0;
  resp_t cur  = '0;
  int    wait1 = 0;
  bit    started = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst) begin
      pend  <= '0;
      wait1 <= 0;
    end else begin
      pend  <= cur;
      wait1 <= (m0_req && m1_req && cur.v0) ? wait1 + 1 : 0;
    end
  end

  always @(negedge clk) begin
    bit e0, e1, g, bad, we;
    logic [31:0] a;
    resp_t nx;
    if (started) begin
      e0 = 0; e1 = 0;
      if (rst) begin
        if (m0_req && m1_req) begin
          e1 = (wait1 >= LIM);
          e0 = !e1;
        end else begin
          e0 = m0_req;
          e1 = m1_req;
        end
      end
      g   = e0 | e1;
      a   = e1 ? m1_addr : m0_addr;
      we  = e1 ? m1_we : m0_we;
      bad = bad_access(e1 ? m1_size : m0_size, a);
      chk("m0_gnt", m0_gnt, e0);
      chk("m1_gnt", m1_gnt, e1);
      chk("core_stall", core_stall, m0_req & !e0);
      chk("mem_en", mem_en, g & !bad);
      chk("mem_we", mem_we, g & !bad & we);
      if (g) begin
        chk("mem_addr", mem_addr, a);
        chk("mem_size", mem_size, e1 ? m1_size : m0_size);
        chk("mem_uns", mem_unsigned, e1 ? m1_unsigned : m0_unsigned);
        chk("mem_wdata", mem_wdata, e1 ? m1_wdata : m0_wdata);
      end
      chk("m0_rvalid", m0_rvalid, pend.v0);
      chk("m1_rvalid", m1_rvalid, pend.v1);
      if (pend.v0) begin
        chk("m0_err", m0_err, pend.err);
        chk("m0_rdata", m0_rdata, pend.ld ? pend.data : 32'h0);
      end
      if (pend.v1) begin
        chk("m1_err", m1_err, pend.err);
        chk("m1_rdata", m1_rdata, pend.ld ? pend.data : 32'h0);
      end
      nx.v0 = e0; nx.v1 = e1; nx.err = g & bad;
      nx.ld = g & !bad & !we; nx.data = data_at(a);
      cur <= nx;
    end
  end

  task automatic drv0(input logic r, input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_size = s; m0_unsigned = 1'b0;
    m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [1:0] s,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] d);
    m1_req = r; m1_we = w; m1_size = s; m1_unsigned = u;
    m1_addr = a; m1_wdata = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drv0(1, 0, 2'b10, 32'h10, 32'h0);
    drv1(1, 0, 2'b10, 0, 32'h40, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      if (i > 0) begin
        chk("rst_rv", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
      end
    end
    step; rst = 1'b1;
    @(negedge clk);
    chk("rel_m0_first", {m0_gnt, m1_gnt}, 2'b10);
    step; drv0(0, 0, 2'b10, 32'h10, 32'h0);
    @(negedge clk);
    chk("rel_m1_gnt", m1_gnt, 1);
    chk("rel_m0_rdata", m0_rdata, 32'hDEADBEEF);
    step; drv1(0, 0, 2'b10, 0, 32'h40, 32'h0);

    step; drv0(1, 0, 2'b10, 32'h10, 32'h0);
    @(negedge clk);
    chk("alone_gnt", m0_gnt, 1);
    step; drv0(0, 0, 2'b10, 32'h10, 32'h0);
    @(negedge clk);
    chk("alone_rv", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("alone_rdata", m0_rdata, 32'hDEADBEEF);

    step;
    drv0(1, 1, 2'b10, 32'h30, 32'hCAFE0001);
    drv1(1, 0, 2'b10, 0, 32'h44, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cont_m1_gnt", m1_gnt, (i % 5) == 4);
      chk("cont_stall", core_stall, (i % 5) == 4);
      step;
    end
    drv0(0, 0, 2'b10, 32'h0, 32'h0);
    drv1(0, 0, 2'b10, 0, 32'h0, 32'h0);

    step; drv1(1, 1, 2'b10, 0, 32'h102, 32'h12345678);
    @(negedge clk);
    chk("mis_gnt", m1_gnt, 1);
    chk("mis_mem_en", mem_en, 0);
    step; drv1(1, 1, 2'b01, 0, 32'h102, 32'h0000ABCD);
    @(negedge clk);
    chk("mis_resp", {m1_rvalid, m1_err}, 2'b11);
    chk("mis_rdata", m1_rdata, 0);
    chk("sh_mem_en", {mem_en, mem_we}, 2'b11);
    step; drv1(0, 0, 2'b00, 0, 32'h0, 32'h0);
    drv0(1, 0, 2'b11, 32'h0, 32'h0);
    @(negedge clk);
    chk("sh_resp", {m1_rvalid, m1_err}, 2'b10);
    chk("sz3_mem_en", mem_en, 0);
    step; drv0(0, 0, 2'b10, 32'h0, 32'h0);
    @(negedge clk);
    chk("sz3_err", {m0_rvalid, m0_err}, 2'b11);

    step; drv0(1, 0, 2'b10, 32'h20, 32'h0);
    step; drv0(0, 0, 2'b10, 32'h0, 32'h0);
    drv1(1, 0, 2'b00, 0, 32'h21, 32'h0);
    @(negedge clk);
    chk("b2b_m0_rdata", m0_rdata, 32'hFFDF0020);
    chk("b2b_rv_n1", {m0_rvalid, m1_rvalid, m1_gnt}, 3'b101);
    step; drv1(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_rv_n2", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("b2b_m1_rdata", m1_rdata, 32'hFFDE0021);

    step;
    drv0(1, 0, 2'b10, 32'h10, 32'h0);
    drv1(1, 0, 2'b10, 0, 32'h50, 32'h0);
    @(negedge clk);
    chk("mid_gnt", m0_gnt, 1);
    #1 rst = 1'b0;
    step;
    @(negedge clk);
    chk("mid_no_rv", m0_rvalid, 0);
    step; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_arb", {m0_gnt, m1_gnt}, (i == 4) ? 2'b01 : 2'b10);
      step;
    end
    drv0(0, 0, 2'b10, 32'h0, 32'h0);
    drv1(0, 0, 2'b10, 0, 32'h0, 32'h0);
    step; step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: m0, the core load/store path (alu_out address, rs2 store data), and m1, the debug/program-loader master.
- Fixed priority to m0, with a starvation guard that forces a grant to m1 after a bounded wait.
- Checks alignment, drives the memory port, and routes the one-cycle-latency read data back to the requester that issued it.
- Produces the core stall request.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive cycles m1 may be denied before it takes priority (range 1..15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- mX_req  input  1  access request, X = 0 or 1, held until granted
- mX_we  input  1  1 = store, 0 = load
- mX_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal
- mX_unsigned  input  1  zero-extend loads (lbu/lhu)
- mX_addr  input  ADDR_W  byte address
- mX_wdata  input  DATA_W  store data, LSB-aligned
- mX_gnt  output  1  request accepted this cycle
- mX_rvalid  output  1  response for this requester's access accepted in the previous cycle
- mX_rdata  output  DATA_W  load data, valid with mX_rvalid
- mX_err  output  1  misaligned or illegal-size access, valid with mX_rvalid
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write
- mem_size  output  2  to memory sb/sh/sw and lb/lh/lw decode
- mem_unsigned  output  1  to memory lbu/lhu decode
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_en with mem_we = 0
- core_stall  output  1  m0_req & ~m0_gnt

Behaviour:
- Reset (rst = 0 at a clk edge):
  - starve counter = 0, response tag = none.
  - mX_rvalid, mX_err and mX_rdata are all 0 the following cycle.
  - A read in flight when reset is asserted produces no response.
  - While rst = 0, no gnt and no mem_en are asserted.
- Arbitration is combinational each cycle from the req inputs and the registered state:
  - Only one requester active: that requester is granted.
  - Both active and starve counter < STARVE_LIMIT: m0 is granted; counter increments.
  - Both active and starve counter = STARVE_LIMIT: m1 is granted; counter clears.
  - Counter clears whenever m1 is granted or m1_req = 0.
  - At most one gnt per cycle. Back-to-back grants every cycle are allowed, with no bubble.
- Granted access, same cycle:
  - mem_* reflect the winner's fields.
  - mem_en = 1 only if the access is legal.
  - Illegal means any of: size = 11; size = 01 with addr[0] = 1; size = 10 with addr[1:0] != 00.
  - Illegal access: gnt still asserted, mem_en = 0, no memory write.
- No grant: mem_en = 0 and mem_we = 0. Other mem_* outputs hold their previous values; the bench must not check them.
- Response stage, registered, one cycle after grant:
  - The winner's mX_rvalid = 1 for exactly one cycle, for loads, stores and illegal accesses alike.
  - mX_err = 1 if the access was illegal.
  - mX_rdata = mem_rdata for a legal load; 0 for stores and errors.
  - The non-winner's rvalid = 0.
- Store data is passed unmodified. Byte/half lane placement and load extension are done by the memory.
- The requester may change its fields or drop req only in the cycle after gnt. Changing them while ungranted is a protocol violation; behaviour is undefined.
- core_stall is combinational, with no registered delay; it feeds the PC hold path.
- A new grant in the same cycle as a response is allowed, since the response tag is pipelined.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both reqs high -> no gnt, mem_en = 0; rvalid, err, rdata all 0; after release, m0 granted first.
- m0 alone: lw from 0x10, mem_rdata = 0xDEADBEEF -> m0_gnt cycle N; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF at N+1; m1_rvalid = 0.
- Contention with STARVE_LIMIT = 4: both req continuously -> grants m0 ×4, m1 ×1, repeating; core_stall = 1 only in the m1-granted cycles.
- Misaligned: m1 sw to addr 0x102 -> m1_gnt = 1, mem_en = 0, next cycle m1_rvalid = 1, m1_err = 1, m1_rdata = 0; sh to 0x102 -> legal, mem_en = 1.
- Back-to-back: m0 lw 0x20 in cycle N, m1 lb 0x21 in cycle N+1 -> responses at N+1 to m0 and at N+2 to m1, each with correct data and no cross-delivery.
- Reset mid-read: m0 lw granted, rst = 0 at the next edge -> no m0_rvalid; after release the arbiter starts from its reset state (starve counter = 0).
